// File: rtl/fp_pkg.sv
// Shared widths, classes and constants for the parametrised IEEE-754 adder.
package fp_pkg;

  localparam int unsigned MAX_W = 64;

  localparam int unsigned FLG_INV = 3;
  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_UNF = 1;
  localparam int unsigned FLG_INX = 0;

  typedef enum logic [2:0] {
    ZERO,
    DEN,
    NORM,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

  function automatic int unsigned word_w(input int unsigned exp_w, input int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int unsigned sig_w(input int unsigned man_w);
    return man_w + 1;
  endfunction

  function automatic int unsigned ext_w(input int unsigned man_w);
    return man_w + 4;
  endfunction

  // Canonical quiet NaN {0, all-ones, 1, zeros}, right-aligned in MAX_W bits.
  function automatic logic [MAX_W-1:0] canon_qnan(input int unsigned exp_w, input int unsigned man_w);
    logic [MAX_W-1:0] q;
    q = '0;
    for (int unsigned i = 0; i < exp_w; i++) q[man_w + i] = 1'b1;
    q[man_w - 1] = 1'b1;
    return q;
  endfunction

  function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                         input logic man_zero, input logic man_msb);
    if (exp_ones) begin
      if (man_zero) return INF;
      return man_msb ? QNAN : SNAN;
    end
    if (exp_zero) return man_zero ? ZERO : DEN;
    return NORM;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [CNT_W-1:0] count
);

  logic found;

  always_comb begin
    count = CNT_W'(WIDTH);
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && in_vec[WIDTH-1-i]) begin
        count = CNT_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Pipelined IEEE-754 add/sub: unpack/swap, align, add, normalise/round/pack.
// All four stages advance together under a single output-driven stall.
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_res,
  output logic [3:0]             out_flags
);

  localparam int unsigned W  = word_w(EXP_W, MAN_W);
  localparam int unsigned SW = sig_w(MAN_W);
  localparam int unsigned XW = ext_w(MAN_W);
  localparam int unsigned CW = $clog2(XW + 1);
  localparam logic [MAX_W-1:0] QNAN_FULL = canon_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]     CANON_NAN = QNAN_FULL[W-1:0];
  localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);

  typedef struct packed {
    logic         hit;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } spec_t;

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- S1: unpack, classify, order by magnitude
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, x_e, y_e;
  logic [MAN_W-1:0] ma, mb, x_m, y_m;
  logic             x_s;
  fp_class_e        ca, cb;
  logic             a_big;
  spec_t            s1_sp_d;

  assign sa    = in_a[W-1];
  assign sb    = in_b[W-1] ^ in_sub;
  assign ea    = in_a[W-2:MAN_W];
  assign eb    = in_b[W-2:MAN_W];
  assign ma    = in_a[MAN_W-1:0];
  assign mb    = in_b[MAN_W-1:0];
  assign ca    = classify(ea == '0, &ea, ma == '0, ma[MAN_W-1]);
  assign cb    = classify(eb == '0, &eb, mb == '0, mb[MAN_W-1]);
  assign a_big = {ea, ma} >= {eb, mb};

  always_comb begin
    if (a_big) begin
      x_s = sa; x_e = ea; x_m = ma; y_e = eb; y_m = mb;
    end else begin
      x_s = sb; x_e = eb; x_m = mb; y_e = ea; y_m = ma;
    end
  end

  always_comb begin
    s1_sp_d = '0;
    if (ca == QNAN || ca == SNAN || cb == QNAN || cb == SNAN) begin
      s1_sp_d.hit          = 1'b1;
      s1_sp_d.res          = CANON_NAN;
      s1_sp_d.flg[FLG_INV] = (ca == SNAN) || (cb == SNAN);
    end else if (ca == INF && cb == INF && (sa ^ sb)) begin
      s1_sp_d.hit          = 1'b1;
      s1_sp_d.res          = CANON_NAN;
      s1_sp_d.flg[FLG_INV] = 1'b1;
    end else if (ca == INF || cb == INF) begin
      // the infinite operand always sorts to X, so X's sign is the result sign
      s1_sp_d.hit = 1'b1;
      s1_sp_d.res = {x_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic             s1_v, s1_sx, s1_sub;
  logic [EXP_W-1:0] s1_ex, s1_ey;
  logic [SW-1:0]    s1_sigx, s1_sigy;
  spec_t            s1_sp;

  // ---------------- S2: align Y to X with guard, round and sticky
  logic [EXP_W-1:0] d;
  logic [SW+1:0]    y_tmp, y_sh;
  logic             y_st;

  assign d     = s1_ex - s1_ey;
  assign y_tmp = {s1_sigy, 2'b00};

  always_comb begin
    y_sh = '0;
    y_st = 1'b0;
    if (32'(d) >= SW + 2) begin
      y_st = |s1_sigy;
    end else begin
      y_sh = y_tmp >> d;
      for (int unsigned i = 0; i < SW + 2; i++) begin
        if (i < 32'(d)) y_st = y_st | y_tmp[i];
      end
    end
  end

  logic             s2_v, s2_sx, s2_sub;
  logic [EXP_W-1:0] s2_ex;
  logic [XW-1:0]    s2_x, s2_y;
  spec_t            s2_sp;

  // ---------------- S3: significand add/subtract (X >= Y so never negative)
  logic [XW:0] sum_d;
  assign sum_d = s2_sub ? ({1'b0, s2_x} - {1'b0, s2_y}) : ({1'b0, s2_x} + {1'b0, s2_y});

  logic             s3_v, s3_sx, s3_sub;
  logic [EXP_W-1:0] s3_ex;
  logic [XW:0]      s3_sum;
  spec_t            s3_sp;

  // ---------------- S4: normalise, round to nearest even, pack
  logic [CW-1:0]  lz;
  logic [31:0]    lim, sh;
  logic [XW-1:0]  n;
  logic [EXP_W:0] e_n, e_f;
  logic [SW:0]    rnd;
  logic           g, r, s, rup, ovf, inx, unf, r_sign;
  logic [W-1:0]   res4;
  logic [3:0]     flg4;

  fp_lzc #(.WIDTH(XW), .CNT_W(CW)) u_lzc (
    .in_vec (s3_sum[XW-1:0]),
    .count  (lz)
  );

  always_comb begin
    n   = '0;
    e_n = '0;
    sh  = '0;
    lim = 32'(s3_ex) - 32'd1;
    if (s3_sum[XW]) begin
      n   = {s3_sum[XW:2], s3_sum[1] | s3_sum[0]};
      e_n = {1'b0, s3_ex} + 1'b1;
    end else begin
      // shift is capped so the exponent stops at 1; an unnormalised result is denormal
      sh  = (32'(lz) < lim) ? 32'(lz) : lim;
      n   = s3_sum[XW-1:0] << sh;
      e_n = n[XW-1] ? ({1'b0, s3_ex} - (EXP_W+1)'(sh)) : '0;
    end
    g   = n[2];
    r   = n[1];
    s   = n[0];
    rup = g & (r | s | n[3]);
    rnd = {1'b0, n[XW-1:3]} + (SW+1)'(rup);
    if (rnd[SW])                         e_f = e_n + 1'b1;
    else if (e_n == '0 && rnd[SW-1])     e_f = {{EXP_W{1'b0}}, 1'b1};
    else                                 e_f = e_n;
    ovf    = e_f >= {1'b0, {EXP_W{1'b1}}};
    inx    = g | r | s | ovf;
    unf    = (e_f == '0) & inx;
    r_sign = (s3_sum == '0) ? (s3_sx & ~s3_sub) : s3_sx;
    if (ovf) res4 = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else     res4 = {r_sign, e_f[EXP_W-1:0], rnd[MAN_W-1:0]};
    flg4          = '0;
    flg4[FLG_OVF] = ovf;
    flg4[FLG_UNF] = unf;
    flg4[FLG_INX] = inx;
    if (s3_sp.hit) begin
      res4 = s3_sp.res;
      flg4 = s3_sp.flg;
    end
  end

  // ---------------- stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s1_sx     <= 1'b0;
      s1_sub    <= 1'b0;
      s1_ex     <= '0;
      s1_ey     <= '0;
      s1_sigx   <= '0;
      s1_sigy   <= '0;
      s1_sp     <= '0;
      s2_v      <= 1'b0;
      s2_sx     <= 1'b0;
      s2_sub    <= 1'b0;
      s2_ex     <= '0;
      s2_x      <= '0;
      s2_y      <= '0;
      s2_sp     <= '0;
      s3_v      <= 1'b0;
      s3_sx     <= 1'b0;
      s3_sub    <= 1'b0;
      s3_ex     <= '0;
      s3_sum    <= '0;
      s3_sp     <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_flags <= '0;
    end else if (adv) begin
      s1_v      <= in_valid;
      s1_sx     <= x_s;
      s1_sub    <= sa ^ sb;
      s1_ex     <= (x_e == '0) ? EXP_ONE : x_e;
      s1_ey     <= (y_e == '0) ? EXP_ONE : y_e;
      s1_sigx   <= {|x_e, x_m};
      s1_sigy   <= {|y_e, y_m};
      s1_sp     <= s1_sp_d;
      s2_v      <= s1_v;
      s2_sx     <= s1_sx;
      s2_sub    <= s1_sub;
      s2_ex     <= s1_ex;
      s2_x      <= {s1_sigx, 3'b000};
      s2_y      <= {y_sh, y_st};
      s2_sp     <= s1_sp;
      s3_v      <= s2_v;
      s3_sx     <= s2_sx;
      s3_sub    <= s2_sub;
      s3_ex     <= s2_ex;
      s3_sum    <= sum_d;
      s3_sp     <= s2_sp;
      out_valid <= s3_v;
      out_res   <= res4;
      out_flags <= flg4;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed-vector bench for fp_add_pipe at single precision and EXP_W=5/MAN_W=10.
module tb_fp_add_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_res;
  logic [3:0]  out_flags;
  logic        in_valid_h, in_ready_h, in_sub_h, out_valid_h, out_ready_h;
  logic [15:0] in_a_h, in_b_h, out_res_h;
  logic [3:0]  out_flags_h;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t        vt[19];
  vec_t        vh[4];
  logic [31:0] fl[10];

  fp_add_pipe u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags)
  );

  fp_add_pipe #(.EXP_W(5), .MAN_W(10)) u_half (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_h),
    .in_ready  (in_ready_h),
    .in_a      (in_a_h),
    .in_b      (in_b_h),
    .in_sub    (in_sub_h),
    .out_valid (out_valid_h),
    .out_ready (out_ready_h),
    .out_res   (out_res_h),
    .out_flags (out_flags_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input bit half, input vec_t v);
    int          lat;
    logic        ov;
    logic [31:0] r;
    logic [3:0]  f;
    @(negedge clk);
    if (half) begin
      in_a_h = v.a[15:0]; in_b_h = v.b[15:0]; in_sub_h = v.sub; in_valid_h = 1'b1;
    end else begin
      in_a = v.a; in_b = v.b; in_sub = v.sub; in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_valid_h = 1'b0;
    lat = 1;
    ov  = half ? out_valid_h : out_valid;
    while (!ov && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      ov = half ? out_valid_h : out_valid;
    end
    r = half ? {16'h0, out_res_h} : out_res;
    f = half ? out_flags_h : out_flags;
    check({tag, "_lat"}, lat, 4);
    check({tag, "_res"}, r, v.res);
    check({tag, "_flg"}, f, v.flg);
  endtask

  initial begin
    int sent, got, extra;
    checks = 0; errors = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    in_valid_h = 1'b0; in_a_h = '0; in_b_h = '0; in_sub_h = 1'b0; out_ready_h = 1'b1;

    vt[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0};
    vt[1]  = '{32'h461C4000, 32'hC5FA0000, 1'b0, 32'h44FA0000, 4'h0};
    vt[2]  = '{32'h461C4000, 32'h45FA0000, 1'b1, 32'h44FA0000, 4'h0};
    vt[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1};
    vt[4]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'h1};
    vt[5]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0};
    vt[6]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8};
    vt[7]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0};
    vt[8]  = '{32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'h8};
    vt[9]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5};
    vt[10] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'h0};
    vt[11] = '{32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'h0};
    vt[12] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0};
    vt[13] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0};
    vt[14] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'h0};
    vt[15] = '{32'hBF800000, 32'hC0000000, 1'b0, 32'hC0400000, 4'h0};
    vt[16] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'h0};
    vt[17] = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 4'h1};
    vt[18] = '{32'h4B800000, 32'h40400000, 1'b0, 32'h4B800002, 4'h1};

    vh[0]  = '{32'h3C00, 32'h3C00, 1'b0, 32'h4000, 4'h0};
    vh[1]  = '{32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'h5};
    vh[2]  = '{32'h0001, 32'h0001, 1'b0, 32'h0002, 4'h0};
    vh[3]  = '{32'h3C00, 32'h3C00, 1'b1, 32'h0000, 4'h0};

    fl = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
           32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_half_valid", out_valid_h, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_half_in_ready", in_ready_h, 1);

    for (int i = 0; i < 19; i++) run_vec($sformatf("v%0d", i), 1'b0, vt[i]);
    for (int i = 0; i < 4; i++) run_vec($sformatf("h%0d", i), 1'b1, vh[i]);

    // back-to-back stream with a 3-cycle consumer stall
    sent = 0; got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c <= 8);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_a = fl[sent]; in_b = fl[0]; in_sub = 1'b0;
      end
      #1;
      if (!out_ready) begin
        check($sformatf("stall%0d_valid", c), out_valid, 1);
        check($sformatf("stall%0d_in_ready", c), in_ready, 0);
      end
      if (out_valid && out_ready) begin
        check($sformatf("stream%0d_res", got), out_res, fl[got + 1]);
        check($sformatf("stream%0d_flg", got), out_flags, 0);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_count", got, 8);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (out_valid) extra++;
    end
    check("stream_no_dup", extra, 0);

    // asynchronous reset with operations in flight
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = fl[c]; in_b = fl[0]; in_sub = 1'b0; out_ready = 1'b1;
    end
    #1;
    check("midrst_pre_valid", out_valid, 1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_res", out_res, 0);
    check("midrst_out_flags", out_flags, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (out_valid) extra++;
    end
    check("midrst_no_stale", extra, 0);
    run_vec("post_rst", 1'b0, vt[0]);
    run_vec("post_rst_h", 1'b1, vh[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
Parametrised, pipelined IEEE-754 adder/subtractor with valid/ready handshake, round-to-nearest-even and exception flags.
Generalises the combinational single-precision adder to any exponent/mantissa width, an add/sub mode and a 4-stage registered datapath.
Gradual underflow is supported on input and output.
Sits between operand-issue logic and the result writeback in the FP datapath.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored mantissa fraction width (>=2); word width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands present
in_ready  out  1  block accepts operands this cycle
in_a  in  W  operand A
in_b  in  W  operand B
in_sub  in  1  1: A-B, 0: A+B (flips B sign at stage 1)
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_res  out  W  result
out_flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset: every stage valid bit =0, out_valid=0, out_res=0, out_flags=0. Reset mid-operation discards all in-flight ops. in_ready=1 after reset.
- Advance: adv = ~out_valid | out_ready. in_ready = adv. All four stages shift together when adv=1 and hold when adv=0. Bubbles propagate as valid=0.
- Transfer on in_valid&in_ready. Latency is exactly 4 cycles with no stall. Throughput is 1 op/cycle. out_res and out_flags stay stable while out_valid&~out_ready.
- S1, unpack/swap:
  - Hidden bit = |exp. An exp of 0 is treated as exp 1 (denormal).
  - Order operands by magnitude {exp,man}. Larger goes to X.
  - Classify zero, denormal, inf, qNaN, sNaN.
- S2, align: shift Y significand right by expX-expY. Keep guard and round bits. Sticky = OR of all bits shifted out. A shift >= MAN_W+3 gives Y=0 with sticky=|Y.
- S3, add: effective subtract = signX^signY. Use an (MAN_W+4)-bit add or subtract including G/R/S. Result sign = signX.
- S4, normalise/round/pack:
  - On carry-out, shift right 1 (sticky absorbs) and increment exponent.
  - Otherwise left shift by the leading-zero count, limited so the exponent does not go below 1. A limited shift yields a denormal with exp field 0.
  - Round RNE on G/R/S. A mantissa carry after rounding increments the exponent.
  - exp reaching all-ones gives inf with overflow=1 and inexact=1.
- Special cases, resolved in S1 and carried alongside; they override the arithmetic result:
  - Any NaN input gives canonical qNaN {0, all-ones, 1, zeros}. invalid=1 only when an input is an sNaN.
  - inf-inf under effective subtraction gives canonical qNaN with invalid=1.
  - inf op finite gives inf with X's sign.
  - Exact zero from a nonzero effective subtract gives +0.
  - (-0)+(-0) gives -0. (+0)+(-0) gives +0.
- Flags:
  - inexact = G|R|S after normalisation, or overflow.
  - underflow = tiny after rounding and inexact.
  - Flags are 0 for exact results and for qNaN propagation.

Decomposition:
- Package fp_pkg:
  - Width helper functions: W, SIG_W = MAN_W+1, EXT_W = MAN_W+4.
  - Canonical qNaN constant function.
  - Flag bit index constants: FLG_INV=3, FLG_OVF=2, FLG_UNF=1, FLG_INX=0.
  - Class enum: ZERO, DEN, NORM, INF, QNAN, SNAN.
- One sub-module fp_lzc (parametrised leading-zero counter, width EXT_W, combinational) used in S4.
- Stage registers and the handshake stay in fp_add_pipe.

Test Plan:
- Default widths: 0x3F800000 + 0x40000000 -> 0x40400000 after 4 cycles, flags 0. Then 0x461C4000 + 0xC5FA0000 -> 0x44FA0000. The same pair with in_sub=1 and B=0x45FA0000 -> 0x44FA0000.
- Rounding:
  - 0x3F800000 + 0x33800000 (tie) -> 0x3F800000, inexact=1.
  - 0x3F800000 + 0x33C00000 -> 0x3F800001, inexact=1.
  - 0x3F800000 - 0x3F800000 -> 0x00000000, flags 0.
- Specials:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid=1.
  - 0x7F800000 + 0x3F800000 -> 0x7F800000.
  - 0x7F800001 + 0 -> 0x7FC00000, invalid=1.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1.
- Denormals:
  - 0x00000001 + 0x00000001 -> 0x00000002.
  - 0x00800000 - 0x00000001 -> 0x007FFFFF, flags 0.
  - 0x80000000 + 0x80000000 -> 0x80000000.
- Handshake: stream 8 back-to-back ops, hold out_ready=0 for 3 cycles mid-stream -> no loss or duplication, in_ready=0 while stalled, results in order. Assert rst mid-stream -> out_valid=0 asynchronously and the stream restarts cleanly.
- EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 -> 0x4000. 0x7BFF + 0x7BFF -> 0x7C00, overflow=1.
